// File: rtl/mult_div_unit.sv
// Multi-cycle signed 32-bit multiply/divide built around a single carry-lookahead adder.
// Optional signed remainder output is enabled by defining MULT_DIV_REMAINDER_EN.

module cl_adder (
    input  logic [31:0] input_a,
    input  logic [31:0] input_b,
    input  logic        subtract_ctrl,
    output logic [31:0] sum,
    output logic        carry_out
);
    logic [31:0] b_eff;
    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] carry;

    assign b_eff    = input_b ^ {32{subtract_ctrl}};
    assign g        = input_a & b_eff;
    assign p        = input_a ^ b_eff;
    assign carry[0] = subtract_ctrl;

    // 4-bit lookahead groups, rippling group carries
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_cla
            localparam int B = 4 * gi;
            assign carry[B+1] = g[B] | (p[B] & carry[B]);
            assign carry[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & carry[B]);
            assign carry[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                              | (p[B+2] & p[B+1] & p[B] & carry[B]);
            assign carry[B+4] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                              | (p[B+3] & p[B+2] & p[B+1] & g[B])
                              | (p[B+3] & p[B+2] & p[B+1] & p[B] & carry[B]);
        end
    endgenerate

    assign sum       = p ^ carry[31:0];
    assign carry_out = carry[32];
endmodule

module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_mult,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
`ifdef MULT_DIV_REMAINDER_EN
    output logic [WIDTH-1:0] remainder,
`endif
    output logic [WIDTH-1:0] result,
    output logic             exception,
    output logic             result_ready,
    output logic             busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MULT = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;
    localparam int CNT_W = $clog2(ITER);

    logic [1:0]         state_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mag_reg;
    logic               neg_reg;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [31:0]      adder_a, adder_sum;
    logic             adder_sub, adder_cout;
    logic             start_mult, start_div, div_by_zero, last_iter;
    logic [WIDTH-1:0] signed_low;
    logic             mul_ovf, div_ovf;

    // Magnitude of the most negative value is 0x80000000 as unsigned, so nothing is lost
    assign a_mag = operand_a[WIDTH-1] ? -operand_a : operand_a;
    assign b_mag = operand_b[WIDTH-1] ? -operand_b : operand_b;

    assign start_mult  = (state_reg == IDLE) && ctrl_mult;
    assign start_div   = (state_reg == IDLE) && !ctrl_mult && ctrl_div;
    assign div_by_zero = start_div && (operand_b == '0);
    assign last_iter   = (count_reg == CNT_W'(ITER - 1));

    // Division looks at the remainder after the left shift, multiplication at the upper half
    assign adder_sub = (state_reg == DIV);
    assign adder_a   = adder_sub ? acc_reg[2*WIDTH-2:WIDTH-1] : acc_reg[2*WIDTH-1:WIDTH];

    cl_adder u_adder (
        .input_a       (adder_a),
        .input_b       (mag_reg),
        .subtract_ctrl (adder_sub),
        .sum           (adder_sum),
        .carry_out     (adder_cout)
    );

    always_comb begin
        acc_next = acc_reg;
        if (state_reg == DIV) begin
            // carry_out=1 means no borrow: partial remainder >= divisor, keep the difference
            acc_next = adder_cout ? {adder_sum, acc_reg[WIDTH-2:0], 1'b1}
                                  : {acc_reg[2*WIDTH-2:0], 1'b0};
        end else if (acc_reg[0]) begin
            acc_next = {adder_cout, adder_sum, acc_reg[WIDTH-1:1]};
        end else begin
            acc_next = {1'b0, acc_reg[2*WIDTH-1:1]};
        end
    end

    assign signed_low = neg_reg ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
    assign mul_ovf    = neg_reg ? ((|acc_next[2*WIDTH-1:WIDTH])
                                   || (acc_next[WIDTH-1] && (|acc_next[WIDTH-2:0])))
                                : (|acc_next[2*WIDTH-1:WIDTH-1]);
    // Only 0x80000000 / -1 yields a positive quotient magnitude of 2^31
    assign div_ovf    = !neg_reg && acc_next[WIDTH-1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            count_reg <= '0;
            acc_reg   <= '0;
            mag_reg   <= '0;
            neg_reg   <= 1'b0;
            result    <= '0;
            exception <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    count_reg <= '0;
                    if (start_mult) begin
                        mag_reg   <= a_mag;
                        acc_reg   <= {{WIDTH{1'b0}}, b_mag};
                        neg_reg   <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                        state_reg <= MULT;
                    end else if (div_by_zero) begin
                        result    <= '0;
                        exception <= 1'b1;
                        state_reg <= DONE;
                    end else if (start_div) begin
                        mag_reg   <= b_mag;
                        acc_reg   <= {{WIDTH{1'b0}}, a_mag};
                        neg_reg   <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                        state_reg <= DIV;
                    end
                end
                MULT, DIV: begin
                    acc_reg   <= acc_next;
                    count_reg <= count_reg + 1'b1;
                    if (last_iter) begin
                        result    <= signed_low;
                        exception <= (state_reg == MULT) ? mul_ovf : div_ovf;
                        state_reg <= DONE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef MULT_DIV_REMAINDER_EN
    logic rem_neg_reg;

    // Remainder takes the dividend's sign and only changes when a divide completes
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            remainder   <= '0;
            rem_neg_reg <= 1'b0;
        end else begin
            if (start_div) rem_neg_reg <= operand_a[WIDTH-1];
            if (div_by_zero) begin
                remainder <= '0;
            end else if (state_reg == DIV && last_iter) begin
                if (div_ovf)          remainder <= '0;
                else if (rem_neg_reg) remainder <= -acc_next[2*WIDTH-1:WIDTH];
                else                  remainder <= acc_next[2*WIDTH-1:WIDTH];
            end
        end
    end
`endif

    assign result_ready = (state_reg == DONE);
    assign busy         = (state_reg != IDLE);
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector self-checking bench for mult_div_unit; each vector carries hand-computed
// results. Define MULT_DIV_REMAINDER_EN to also check the remainder port.

module tb_mult_div_unit;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        ctrl_mult = 1'b0;
    logic        ctrl_div = 1'b0;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic [31:0] result;
    logic        exception;
    logic        result_ready;
    logic        busy;
`ifdef MULT_DIV_REMAINDER_EN
    logic [31:0] remainder;
`endif

    int compare_count  = 0;
    int mismatch_count = 0;

    mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .ctrl_mult    (ctrl_mult),
        .ctrl_div     (ctrl_div),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
`ifdef MULT_DIV_REMAINDER_EN
        .remainder    (remainder),
`endif
        .result       (result),
        .exception    (exception),
        .result_ready (result_ready),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compare_count++;
        if (got !== exp) begin
            mismatch_count++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Start an op in cycle 0, then wait (bounded) for result_ready; cycles = DONE cycle index
    task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                          input int pulse_cycle, output int cycles, output int busy_low);
        @(posedge clock); #1;
        ctrl_mult = m; ctrl_div = d; operand_a = a; operand_b = b;
        @(posedge clock); #1;
        ctrl_mult = 1'b0; ctrl_div = 1'b0;
        operand_a = 32'h1234_5678; operand_b = 32'h0000_0000;
        cycles   = 1;
        busy_low = 0;
        while (!result_ready && cycles < 40) begin
            if (!busy) busy_low++;
            if (cycles == pulse_cycle) begin
                ctrl_div  = 1'b1;
                operand_a = 32'd9;
                operand_b = 32'd1;
            end
            @(posedge clock); #1;
            ctrl_div = 1'b0;
            cycles++;
        end
        if (!busy) busy_low++;
    endtask

    task automatic check_op(input string tag, input logic m, input logic d,
                            input logic [31:0] a, input logic [31:0] b, input int pulse_cycle,
                            input logic [31:0] exp_result, input logic exp_exc,
                            input int exp_cycles, input logic [31:0] exp_rem);
        int cycles, busy_low;
        run_op(m, d, a, b, pulse_cycle, cycles, busy_low);
        $display("op %s: a=0x%08h b=0x%08h -> result=0x%08h exc=%0d ready@cycle %0d",
                 tag, a, b, result, exception, cycles);
        check_value({tag, ".cycles"}, 32'(cycles), 32'(exp_cycles));
        check_value({tag, ".result"}, result, exp_result);
        check_value({tag, ".exception"}, 32'(exception), 32'(exp_exc));
        check_value({tag, ".busy_low"}, 32'(busy_low), 32'd0);
`ifdef MULT_DIV_REMAINDER_EN
        check_value({tag, ".remainder"}, remainder, exp_rem);
`else
        if (exp_rem === 32'hxxxx_xxxx) $display("op %s: remainder vector unknown", tag);
`endif
        @(posedge clock); #1;
        check_value({tag, ".ready_after"}, 32'(result_ready), 32'd0);
        check_value({tag, ".busy_after"}, 32'(busy), 32'd0);
        check_value({tag, ".result_hold"}, result, exp_result);
    endtask

    initial begin
        int extra_ready;
        int k;

        repeat (3) @(posedge clock);
        #1;
        check_value("reset.result", result, 32'd0);
        check_value("reset.exception", 32'(exception), 32'd0);
        check_value("reset.ready", 32'(result_ready), 32'd0);
        check_value("reset.busy", 32'(busy), 32'd0);
        reset_n = 1'b1;

        check_op("mul_7x-3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 0, 32'hFFFF_FFEB, 1'b0, 33, 32'd0);
        check_op("div_100/7", 1'b0, 1'b1, 32'd100, 32'd7, 0, 32'd14, 1'b0, 33, 32'd2);
        check_op("div_-100/7", 1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7, 0, 32'hFFFF_FFF2, 1'b0, 33,
                 32'hFFFF_FFFE);
        check_op("mul_ovf", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 0, 32'h0, 1'b1, 33,
                 32'hFFFF_FFFE);
        check_op("mul_min_x1", 1'b1, 1'b0, 32'h8000_0000, 32'd1, 0, 32'h8000_0000, 1'b0, 33,
                 32'hFFFF_FFFE);
        check_op("mul_-5x-6", 1'b1, 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 0, 32'd30, 1'b0, 33,
                 32'hFFFF_FFFE);
        check_op("div_5/0", 1'b0, 1'b1, 32'd5, 32'd0, 0, 32'd0, 1'b1, 1, 32'd0);
        check_op("div_min/-1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 1'b1,
                 33, 32'd0);
        check_op("div_7/-2", 1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, 0, 32'hFFFF_FFFD, 1'b0, 33, 32'd1);
        check_op("both_6x3", 1'b1, 1'b1, 32'd6, 32'd3, 10, 32'd18, 1'b0, 33, 32'd1);

        // The ignored ctrl_div pulse must not start a second operation
        extra_ready = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (result_ready) extra_ready++;
        end
        check_value("both.extra_ready", 32'(extra_ready), 32'd0);
        check_value("both.idle_result", result, 32'd18);

        // Abort a divide with reset in its cycle 10
        @(posedge clock); #1;
        ctrl_div = 1'b1; operand_a = 32'd1000; operand_b = 32'd3;
        @(posedge clock); #1;
        ctrl_div = 1'b0;
        k = 1;
        while (k < 10) begin
            @(posedge clock); #1;
            k++;
        end
        check_value("abort.busy_before", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check_value("abort.result", result, 32'd0);
        check_value("abort.exception", 32'(exception), 32'd0);
        check_value("abort.ready", 32'(result_ready), 32'd0);
        check_value("abort.busy", 32'(busy), 32'd0);
`ifdef MULT_DIV_REMAINDER_EN
        check_value("abort.remainder", remainder, 32'd0);
`endif
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        check_op("mul_2x3", 1'b1, 1'b0, 32'd2, 32'd3, 0, 32'd6, 1'b0, 33, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end
endmodule
